// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, bus-select and FSM state definitions for the processor control path
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Bus select codes above the register file range 0-7
    localparam logic [3:0] SEL_IMM = 4'd8;
    localparam logic [3:0] SEL_G   = 4'd9;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/proc_ctrl_if.sv
// rtl/proc_ctrl_if.sv - bus-select / load-enable bundle between proc_ctrl (master) and the datapath (slave)
// Signals: ir (immediate word), sel (bus select), r_in (R0-R7 loads), a_in, g_in,
// addsub, done, and illegal when PROC_CTRL_ILLEGAL_TRAP_EN is defined.
interface proc_ctrl_if #(
    parameter int IR_W = 16
);
    logic [IR_W-1:0] ir;
    logic [3:0]      sel;
    logic [7:0]      r_in;
    logic            a_in;
    logic            g_in;
    logic            addsub;
    logic            done;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    logic            illegal;
`endif

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    modport master (output ir, sel, r_in, a_in, g_in, addsub, done, illegal);
    modport slave  (input  ir, sel, r_in, a_in, g_in, addsub, done, illegal);
`else
    modport master (output ir, sel, r_in, a_in, g_in, addsub, done);
    modport slave  (input  ir, sel, r_in, a_in, g_in, addsub, done);
`endif

endinterface

// File: rtl/dec3to8.sv
// rtl/dec3to8.sv - gated 3-to-8 one-hot decoder for register load enables
// Ports: en (gate), sel (register index), y (one-hot output, all zero when en=0)
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - instruction register and T0-T3 sequencer driving bus select and load enables
// Ports: clk, resetn (async active-low), run (start, sampled in T0), din (instruction word),
// bus (proc_ctrl_if master: ir, sel, r_in, a_in, g_in, addsub, done[, illegal]).
// Optional feature macro: PROC_CTRL_ILLEGAL_TRAP_EN - opcode 1xx pulses illegal instead of done.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int IR_W = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            run,
    input  logic [IR_W-1:0] din,
    proc_ctrl_if.master     bus
);

    state_t          state;
    state_t          state_nxt;
    logic [IR_W-1:0] ir_q;

    logic [2:0] opcode;
    logic       imm;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [3:0] op2_sel;
    logic       rx_load;
    logic       unused_ir_bits;

    assign opcode  = ir_q[15:13];
    assign imm     = ir_q[12];
    assign rx      = ir_q[11:9];
    assign ry      = ir_q[2:0];
    assign op2_sel = imm ? SEL_IMM : {1'b0, ry};

    // Immediate payload bits are consumed by the mux through ir, not here
    assign unused_ir_bits = ^ir_q[8:3];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= T0;
            ir_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == T0 && run) begin
                ir_q <= din;
            end
        end
    end

    // Outputs decode from state and ir only, so an async reset clears them at once
    always_comb begin
        state_nxt  = state;
        bus.sel    = 4'd0;
        bus.a_in   = 1'b0;
        bus.g_in   = 1'b0;
        bus.addsub = 1'b0;
        bus.done   = 1'b0;
        rx_load    = 1'b0;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        bus.illegal = 1'b0;
`endif
        case (state)
            T0: begin
                if (run) begin
                    state_nxt = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus.sel   = op2_sel;
                        rx_load   = 1'b1;
                        bus.done  = 1'b1;
                        state_nxt = T0;
                    end
                    OP_MVT: begin
                        // The mux does the shift; only the immediate path is selected here
                        bus.sel   = SEL_IMM;
                        rx_load   = 1'b1;
                        bus.done  = 1'b1;
                        state_nxt = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        bus.sel   = {1'b0, rx};
                        bus.a_in  = 1'b1;
                        state_nxt = T2;
                    end
                    default: begin
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
                        bus.illegal = 1'b1;
`else
                        bus.done    = 1'b1;
`endif
                        state_nxt = T0;
                    end
                endcase
            end
            T2: begin
                bus.sel    = op2_sel;
                bus.addsub = opcode[0];
                bus.g_in   = 1'b1;
                state_nxt  = T3;
            end
            T3: begin
                bus.sel   = SEL_G;
                rx_load   = 1'b1;
                bus.done  = 1'b1;
                state_nxt = T0;
            end
            default: begin
                state_nxt = T0;
            end
        endcase
    end

    assign bus.ir = ir_q;

    dec3to8 u_dec3to8 (
        .en  (rx_load),
        .sel (rx),
        .y   (bus.r_in)
    );

endmodule

// File: tb/tb_proc_ctrl.sv
// tb/tb_proc_ctrl.sv - self-checking bench for proc_ctrl with randomized instruction stream
module tb_proc_ctrl;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] r_in;
        logic       a_in;
        logic       g_in;
        logic       addsub;
        logic       done;
        logic       illegal;
    } exp_t;

    typedef exp_t seq_t[$];

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        run;
    logic [15:0] din;

    int errors = 0;
    int checks = 0;

    proc_ctrl_if #(.IR_W(16)) bus ();

    proc_ctrl #(.IR_W(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .run    (run),
        .din    (din),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int sel, input int r, input bit a, input bit g,
                                input bit as, input bit d, input bit il);
        exp_t e;
        e.sel     = 4'(sel);
        e.r_in    = 8'(r);
        e.a_in    = a;
        e.g_in    = g;
        e.addsub  = as;
        e.done    = d;
        e.illegal = il;
        return e;
    endfunction

    function automatic exp_t snap();
        exp_t s;
        s.sel    = bus.sel;
        s.r_in   = bus.r_in;
        s.a_in   = bus.a_in;
        s.g_in   = bus.g_in;
        s.addsub = bus.addsub;
        s.done   = bus.done;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        s.illegal = bus.illegal;
`else
        s.illegal = 1'b0;
`endif
        return s;
    endfunction

    // Expected per-cycle outputs from T1 onward, derived from the instruction rules
    function automatic seq_t model(input logic [15:0] w);
        seq_t q;
        int op, imm, rx, ry, op2, onehot;
        op     = int'(w) / 8192;
        imm    = (int'(w) / 4096) % 2;
        rx     = (int'(w) / 512) % 8;
        ry     = int'(w) % 8;
        op2    = (imm == 1) ? 8 : ry;
        onehot = 1 << rx;
        case (op)
            0: q.push_back(mk(op2, onehot, 0, 0, 0, 1, 0));
            1: q.push_back(mk(8, onehot, 0, 0, 0, 1, 0));
            2, 3: begin
                q.push_back(mk(rx, 0, 1, 0, 0, 0, 0));
                q.push_back(mk(op2, 0, 0, 1, op == 3, 0, 0));
                q.push_back(mk(9, onehot, 0, 0, 0, 1, 0));
            end
            default: q.push_back(TRAP ? mk(0, 0, 0, 0, 0, 0, 1) : mk(0, 0, 0, 0, 0, 1, 0));
        endcase
        return q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in T0 and advance past the fetch edge
    task automatic fetch(input logic [15:0] w, input bit hold);
        din = w;
        run = 1'b1;
        step();
        if (!hold) run = 1'b0;
    endtask

    task automatic test_reset();
        exp_t a;
        resetn = 1'b0;
        run    = 1'b1;
        din    = 16'(($urandom));
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = snap();
        checks++;
        if (a !== exp_t'(0)) begin errors++; $display("FAIL reset_outputs: got %h want %h", a, exp_t'(0)); end
        checks++;
        if (bus.ir !== 16'h0) begin errors++; $display("FAIL reset_ir: got %h want 0000", bus.ir); end
        resetn = 1'b1;
        din    = 16'h1405;
        step();
        run = 1'b0;
        @(negedge clk);
        a = snap();
        checks++;
        if (a !== mk(8, 8'h04, 0, 0, 0, 1, 0)) begin errors++; $display("FAIL reset_first_fetch: got %h want %h", a, mk(8, 8'h04, 0, 0, 0, 1, 0)); end
        checks++;
        if (bus.ir !== 16'h1405) begin errors++; $display("FAIL reset_first_ir: got %h want 1405", bus.ir); end
        step();
    endtask

    task automatic test_mv_imm();
        exp_t a;
        fetch(16'h1405, 1'b0);
        @(negedge clk);
        a = snap();
        checks++;
        if (a !== mk(8, 8'h04, 0, 0, 0, 1, 0)) begin errors++; $display("FAIL mv_imm_t1: got %h want %h", a, mk(8, 8'h04, 0, 0, 0, 1, 0)); end
        step();
        @(negedge clk);
        a = snap();
        checks++;
        if (a !== exp_t'(0)) begin errors++; $display("FAIL mv_imm_back_t0: got %h want %h", a, exp_t'(0)); end
        step();
    endtask

    task automatic test_mvt();
        exp_t a;
        fetch(16'h32A5, 1'b0);
        @(negedge clk);
        a = snap();
        checks++;
        if (a !== mk(8, 8'h02, 0, 0, 0, 1, 0)) begin errors++; $display("FAIL mvt_t1: got %h want %h", a, mk(8, 8'h02, 0, 0, 0, 1, 0)); end
        checks++;
        if (bus.ir !== 16'h32A5) begin errors++; $display("FAIL mvt_ir: got %h want 32a5", bus.ir); end
        step();
    endtask

    task automatic test_sub_reg();
        exp_t a;
        exp_t e[4];
        e[0] = mk(3, 0, 1, 0, 0, 0, 0);
        e[1] = mk(3, 0, 0, 1, 1, 0, 0);
        e[2] = mk(9, 8'h08, 0, 0, 0, 1, 0);
        e[3] = exp_t'(0);
        fetch(16'h6603, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = snap();
            checks++;
            if (a !== e[i]) begin errors++; $display("FAIL sub_reg_cycle%0d: got %h want %h", i + 1, a, e[i]); end
            step();
        end
    endtask

    task automatic test_random();
        exp_t a;
        seq_t q;
        logic [15:0] w;
        logic [15:0] prev_ir;
        for (int n = 0; n < 40; n++) begin
            prev_ir = bus.ir;
            repeat ($urandom_range(0, 2)) begin
                run = 1'b0;
                din = 16'($urandom);
                @(negedge clk);
                a = snap();
                checks++;
                if (a !== exp_t'(0) || bus.ir !== prev_ir) begin
                    errors++;
                    $display("FAIL random_idle: got %h ir %h want %h ir %h", a, bus.ir, exp_t'(0), prev_ir);
                end
                step();
            end
            w = 16'($urandom);
            q = model(w);
            fetch(w, 1'b0);
            foreach (q[i]) begin
                run = 1'($urandom);
                din = 16'($urandom);
                @(negedge clk);
                a = snap();
                checks++;
                if (a !== q[i] || bus.ir !== w) begin
                    errors++;
                    $display("FAIL random_w%h_c%0d: got %h ir %h want %h ir %h", w, i + 1, a, bus.ir, q[i], w);
                end
                step();
            end
            run = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        exp_t a;
        seq_t q;
        logic [15:0] w;
        run = 1'b1;
        for (int n = 0; n < 20; n++) begin
            w   = 16'($urandom);
            q   = model(w);
            din = w;
            @(negedge clk);
            a = snap();
            checks++;
            if (a !== exp_t'(0)) begin errors++; $display("FAIL b2b_fetch_t0: got %h want %h", a, exp_t'(0)); end
            step();
            foreach (q[i]) begin
                @(negedge clk);
                a = snap();
                checks++;
                if (a !== q[i] || bus.ir !== w) begin
                    errors++;
                    $display("FAIL b2b_w%h_c%0d: got %h ir %h want %h ir %h", w, i + 1, a, bus.ir, q[i], w);
                end
                din = 16'($urandom);
                step();
            end
        end
        run = 1'b0;
    endtask

    task automatic test_abort();
        exp_t a;
        fetch(16'h4A01, 1'b0);
        step();
        @(negedge clk);
        checks++;
        if (bus.g_in !== 1'b1) begin errors++; $display("FAIL abort_t2_g_in: got %b want 1", bus.g_in); end
        #1 resetn = 1'b0;
        #1;
        a = snap();
        checks++;
        if (a !== exp_t'(0) || bus.ir !== 16'h0) begin
            errors++;
            $display("FAIL abort_immediate: got %h ir %h want %h ir 0000", a, bus.ir, exp_t'(0));
        end
        step();
        a = snap();
        checks++;
        if (a !== exp_t'(0)) begin errors++; $display("FAIL abort_no_done: got %h want %h", a, exp_t'(0)); end
        @(negedge clk);
        resetn = 1'b1;
        step();
        @(negedge clk);
        a = snap();
        checks++;
        if (a !== exp_t'(0)) begin errors++; $display("FAIL abort_idle_after: got %h want %h", a, exp_t'(0)); end
        step();
    endtask

    task automatic test_illegal_opcode();
        exp_t a;
        exp_t e;
        e = TRAP ? mk(0, 0, 0, 0, 0, 0, 1) : mk(0, 0, 0, 0, 0, 1, 0);
        fetch(16'hE000, 1'b0);
        @(negedge clk);
        a = snap();
        checks++;
        if (a !== e) begin errors++; $display("FAIL opcode_e000_t1: got %h want %h", a, e); end
        step();
        @(negedge clk);
        a = snap();
        checks++;
        if (a !== exp_t'(0)) begin errors++; $display("FAIL opcode_e000_back_t0: got %h want %h", a, exp_t'(0)); end
        step();
    endtask

    initial begin
        resetn = 1'b0;
        run    = 1'b0;
        din    = 16'h0;
        test_reset();
        test_mv_imm();
        test_mvt();
        test_sub_reg();
        test_illegal_opcode();
        test_abort();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_ctrl.md
# proc_ctrl

Instruction control unit for the simple processor: holds the instruction register and sequences each instruction through states T0–T3. It drives the bus multiplexer's 4-bit select and supplies that mux's immediate input (`ir`). It also drives the register, accumulator and result load enables that consume the bus. It is the producer side of the bus-select interface: `mux` consumes `sel` and `ir`, and `proc_ctrl` generates them cycle by cycle.

## Interface
- `IR_W`, default 16: instruction width (fixed format below; not meant to change).
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `run` in 1: start request, sampled only in T0.
- `din` in 16: instruction word, captured into `ir` when leaving T0.
- `ir` out 16: instruction register; feeds mux input 8 (immediate / MVT path).
- `sel` out 4: bus select. 0–7 = R0–R7, 8 = immediate from `ir`, 9 = G.
- `r_in` out 8: one-hot load enables for R0–R7.
- `a_in` out 1: load enable for A.
- `g_in` out 1: load enable for G.
- `addsub` out 1: ALU operation, 0 = add, 1 = subtract.
- `done` out 1: one-cycle pulse when an instruction completes.
- `illegal` out 1: one-cycle pulse; exists only with the trap feature enabled.

## Operation
- Instruction format:
  - [15:13] opcode.
  - [12] imm flag.
  - [11:9] rX.
  - [8:0] 9-bit immediate (MVT uses [7:0]).
  - [2:0] rY.
- Opcodes:
  - MV = 000: rX ← rY or imm.
  - MVT = 001: rX ← imm8 << 8. The mux performs the shift; this block only selects 8.
  - ADD = 010: rX ← rX + op2.
  - SUB = 011: rX ← rX − op2.
  - 1xx: unused.
- op2 is the immediate path (`sel`=8) when imm = 1, otherwise rY.
- States:
  - T0: idle/fetch. If `run`=1, `ir` ← `din` at the edge and the FSM moves to T1; otherwise it stays in T0.
  - T1, MV/MVT: `sel`=op2 (MVT always 8), `r_in[rX]`=1, `done`=1, then → T0.
  - T1, ADD/SUB: `sel`=rX, `a_in`=1, then → T2.
  - T2: `sel`=op2, `addsub`=opcode[0], `g_in`=1, then → T3.
  - T3: `sel`=9, `r_in[rX]`=1, `done`=1, then → T0.
- All outputs except `ir` are combinational functions of state and `ir` (Moore). There are no registered output delays.
- Default output values in any state not listed above: `sel`=0, all enables 0, `addsub`=0.

## Timing
- Reset, asserted asynchronously: state=T0, `ir`=0, `sel`=0, `r_in`=0, `a_in`=`g_in`=`addsub`=`done`=`illegal`=0. These take effect immediately, not at the next edge.
- Latency from `run` sampled high in T0:
  - MV/MVT: 2 cycles, with `done` in T1.
  - ADD/SUB: 4 cycles, with `done` in T3.
- `run` is ignored outside T0. If `run` is held high, a new fetch starts in the cycle after `done` (back-to-back instructions).
- `ir` changes only on the T0→T1 edge and is stable for the rest of the instruction.
- Reset during T1–T3 aborts the instruction. No enable may assert after `resetn` falls.
- `done` and `r_in` are never asserted in T0.
- At most one `r_in` bit is set at any time.

## Configuration
- `PROC_CTRL_ILLEGAL_TRAP_EN` defined:
  - Opcode 1xx in T1 pulses `illegal` for one cycle, asserts no enables and no `done`, then → T0.
- Not defined:
  - The `illegal` port is absent.
  - Opcode 1xx is a NOP: `done`=1 in T1, no enables, then → T0.

## Structure
- `proc_pkg` holds:
  - opcode constants (MV, MVT, ADD, SUB);
  - sel codes (SEL_IMM=8, SEL_G=9);
  - the state enum T0–T3.
- `mux` imports the same opcode and sel constants.
- One sub-module, `dec3to8`, produces the one-hot `r_in` from rX, gated by an enable.

## Test plan
- Reset: hold `resetn`=0 with `run`=1 → all outputs 0, state T0. Release → first fetch on the next edge.
- MV immediate: `din`=16'h1405 (rX=2, imm=1, value 5) → T1 shows `sel`=8, `r_in`=8'h04, `done`=1. The FSM is back in T0 the next cycle.
- MVT: `din`=16'h32A5 (rX=1) → T1 shows `sel`=8, `r_in`=8'h02, `done`=1. `ir`[15:13]=001 is presented to the mux.
- SUB register: `din`=16'h6603 (rX=3, rY=3, imm=0) → expected sequence:
  - T1: `sel`=3, `a_in`.
  - T2: `sel`=3, `addsub`=1, `g_in`.
  - T3: `sel`=9, `r_in`=8'h08, `done`.
  - 4 cycles total.
- Abort: pull `resetn` low during T2 of an ADD → `g_in` drops immediately, no `done`, `ir`=0.
- Opcode 16'hE000:
  - With `PROC_CTRL_ILLEGAL_TRAP_EN`: `illegal` pulses in T1, no `done`.
  - Without it: `done` in T1, no enables.
